// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between an instruction fetch
// port and a data port. Data requests win over fetches in IDLE, an access in
// flight is never preempted, and every RAM access is bounded by a wait
// counter that aborts it after TIMEOUT cycles without an acknowledge.
//
// Handshake: a core port requests by holding *_ren/*_wen high; it sees its
// access as finished when its stall drops (done flag set) and releases the
// result by pulsing core_adv. On the RAM side ram_cs is the request and
// ram_ack the completion; ram_ack is ignored unless ram_cs=1, and ram_addr /
// ram_wdata / ram_we are held constant for the whole time ram_cs=1.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  input  logic        core_adv,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        err_timeout,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  // Last wait-counter value before an unacknowledged access is aborted.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       data_done;
  logic       inst_done;
  logic       mem_req;

  assign mem_req    = mem_ren | mem_wen;
  assign mem_stall  = mem_req & ~data_done;
  assign inst_stall = inst_ren & ~inst_done;
  assign state_dbg  = state;

  // Arbitration FSM with registered RAM strobes, results and done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      inst_data   <= '0;
      mem_din     <= '0;
      data_done   <= 1'b0;
      inst_done   <= 1'b0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      // Pipeline advance consumes completed results; a completion in the
      // same cycle overrides this below because the later assignment wins.
      if (core_adv) begin
        data_done <= 1'b0;
        inst_done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (mem_req && !data_done) begin
            ram_cs    <= 1'b1;
            ram_we    <= mem_wen;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_dout;
            wait_cnt  <= '0;
            state     <= DATA;
          end else if (inst_ren && !inst_done) begin
            ram_cs   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= inst_addr;
            wait_cnt <= '0;
            state    <= INST;
          end
        end

        DATA: begin
          if (ram_ack) begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            if (!ram_we) mem_din <= ram_rdata;
            data_done <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            // Aborted read returns zero; an aborted write keeps mem_din.
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            if (!ram_we) mem_din <= '0;
            data_done   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        INST: begin
          if (ram_ack) begin
            ram_cs    <= 1'b0;
            inst_data <= ram_rdata;
            inst_done <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            ram_cs      <= 1'b0;
            inst_data   <= '0;
            inst_done   <= 1'b1;
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT=4): a cycle-by-cycle vector table with
// hand-computed expectations, plus hand-written reset sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        core_adv;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        err_timeout;
  logic [1:0]  state_dbg;

  int checks;
  int failures;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .mem_stall  (mem_stall),
    .core_adv   (core_adv),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_ack    (ram_ack),
    .err_timeout(err_timeout),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        mr;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    logic        adv;
    logic        ack;
    logic [31:0] rd;
    logic        e_cs;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_is;
    logic        e_ms;
    logic [31:0] e_idata;
    logic [31:0] e_din;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic ir, input logic [31:0] ia,
    input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md,
    input logic adv, input logic ack, input logic [31:0] rd,
    input logic cs, input logic we, input logic [31:0] ad, input logic [31:0] wd,
    input logic is, input logic ms, input logic [31:0] id, input logic [31:0] dn,
    input logic er);
    vec_t r;
    r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ma = ma; r.md = md;
    r.adv = adv; r.ack = ack; r.rd = rd;
    r.e_cs = cs; r.e_we = we; r.e_addr = ad; r.e_wdata = wd;
    r.e_is = is; r.e_ms = ms; r.e_idata = id; r.e_din = dn; r.e_err = er;
    return r;
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    inst_ren  = r.ir;
    inst_addr = r.ia;
    mem_ren   = r.mr;
    mem_wen   = r.mw;
    mem_addr  = r.ma;
    mem_dout  = r.md;
    core_adv  = r.adv;
    ram_ack   = r.ack;
    ram_rdata = r.rd;
  endtask

  task automatic idle_inputs();
    inst_ren  = 1'b0;
    inst_addr = '0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_dout  = '0;
    core_adv  = 1'b0;
    ram_ack   = 1'b0;
    ram_rdata = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Fetch only, ack in first cycle, then held request for 5 cycles.
    vecs.push_back(v(1, 32'h100, 0,0, 0, 0, 0,0, 0,
                     1,0, 32'h100, 0, 1,0, 0, 0, 0));
    vecs.push_back(v(1, 32'h100, 0,0, 0, 0, 0,1, 32'h2408000A,
                     0,0, 32'h100, 0, 0,0, 32'h2408000A, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(1, 32'h100, 0,0, 0, 0, 0,0, 0,
                       0,0, 32'h100, 0, 0,0, 32'h2408000A, 0, 0));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h100, 0, 0,0, 32'h2408000A, 0, 0));

    // Simultaneous fetch and data read: data first, fetch right after.
    vecs.push_back(v(1, 32'h300, 1,0, 32'h200, 32'h55, 0,0, 0,
                     1,0, 32'h200, 32'h55, 1,1, 32'h2408000A, 0, 0));
    vecs.push_back(v(1, 32'h300, 1,0, 32'h200, 32'h55, 0,1, 32'h11112222,
                     0,0, 32'h200, 32'h55, 1,0, 32'h2408000A, 32'h11112222, 0));
    vecs.push_back(v(1, 32'h300, 1,0, 32'h200, 32'h55, 0,0, 0,
                     1,0, 32'h300, 32'h55, 1,0, 32'h2408000A, 32'h11112222, 0));
    vecs.push_back(v(1, 32'h300, 1,0, 32'h200, 32'h55, 0,1, 32'h33334444,
                     0,0, 32'h300, 32'h55, 0,0, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h300, 32'h55, 0,0, 32'h33334444, 32'h11112222, 0));

    // Write with ack on the third cs cycle; mem_din untouched.
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 0, 0,1, 32'h44, 32'hCAFEF00D, 0,0, 0,
                       1,1, 32'h44, 32'hCAFEF00D, 0,1, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(0, 0, 0,1, 32'h44, 32'hCAFEF00D, 0,1, 32'hDEADBEEF,
                     0,0, 32'h44, 32'hCAFEF00D, 0,0, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h44, 32'hCAFEF00D, 0,0, 32'h33334444, 32'h11112222, 0));

    // Read and write together: the write wins.
    vecs.push_back(v(0, 0, 1,1, 32'h80, 32'h77, 0,0, 0,
                     1,1, 32'h80, 32'h77, 0,1, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(0, 0, 1,1, 32'h80, 32'h77, 0,1, 32'h12345678,
                     0,0, 32'h80, 32'h77, 0,0, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h80, 32'h77, 0,0, 32'h33334444, 32'h11112222, 0));

    // Fetch timeout: cs high for 4 cycles, then abort with zero result.
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1, 32'h400, 0,0, 0, 0, 0,0, 0,
                       1,0, 32'h400, 32'h77, 1,0, 32'h33334444, 32'h11112222, 0));
    vecs.push_back(v(1, 32'h400, 0,0, 0, 0, 0,0, 0,
                     0,0, 32'h400, 32'h77, 0,0, 0, 32'h11112222, 1));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h400, 32'h77, 0,0, 0, 32'h11112222, 1));

    // Ack and core_adv in the same cycle: the done flag still sets.
    vecs.push_back(v(0, 0, 1,0, 32'h600, 0, 0,0, 0,
                     1,0, 32'h600, 0, 0,1, 0, 32'h11112222, 1));
    vecs.push_back(v(0, 0, 1,0, 32'h600, 0, 1,1, 32'hABCD0001,
                     0,0, 32'h600, 0, 0,0, 0, 32'hABCD0001, 1));
    vecs.push_back(v(0, 0, 1,0, 32'h600, 0, 0,0, 0,
                     0,0, 32'h600, 0, 0,0, 0, 32'hABCD0001, 1));
    vecs.push_back(v(0, 0, 0,0, 0, 0, 1,0, 0,
                     0,0, 32'h600, 0, 0,0, 0, 32'hABCD0001, 1));

    // Reset block and reset-state checks
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", -1, 32'(ram_cs), 0);
    chk("rst_we", -1, 32'(ram_we), 0);
    chk("rst_addr", -1, ram_addr, 0);
    chk("rst_wdata", -1, ram_wdata, 0);
    chk("rst_idata", -1, inst_data, 0);
    chk("rst_din", -1, mem_din, 0);
    chk("rst_err", -1, 32'(err_timeout), 0);
    chk("rst_state", -1, 32'(state_dbg), 0);
    rst = 1'b1;

    // Table-driven vectors
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      @(posedge clk);
      #1;
      chk("ram_cs", k, 32'(ram_cs), 32'(vecs[k].e_cs));
      chk("ram_we", k, 32'(ram_we), 32'(vecs[k].e_we));
      chk("ram_addr", k, ram_addr, vecs[k].e_addr);
      chk("ram_wdata", k, ram_wdata, vecs[k].e_wdata);
      chk("inst_stall", k, 32'(inst_stall), 32'(vecs[k].e_is));
      chk("mem_stall", k, 32'(mem_stall), 32'(vecs[k].e_ms));
      chk("inst_data", k, inst_data, vecs[k].e_idata);
      chk("mem_din", k, mem_din, vecs[k].e_din);
      chk("err_timeout", k, 32'(err_timeout), 32'(vecs[k].e_err));
    end

    // Reset in the middle of a data access, then clean re-issue.
    idle_inputs();
    mem_ren  = 1'b1;
    mem_addr = 32'h500;
    mem_dout = 32'h99;
    @(posedge clk);
    #1;
    chk("mid_cs_up", 100, 32'(ram_cs), 1);
    chk("mid_addr", 100, ram_addr, 32'h500);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cs", 101, 32'(ram_cs), 0);
    chk("mid_rst_addr", 101, ram_addr, 0);
    chk("mid_rst_err", 101, 32'(err_timeout), 0);
    chk("mid_rst_din", 101, mem_din, 0);
    chk("mid_rst_stall", 101, 32'(mem_stall), 1);
    @(posedge clk);
    #1;
    chk("held_rst_cs", 102, 32'(ram_cs), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reissue_cs", 103, 32'(ram_cs), 1);
    chk("reissue_we", 103, 32'(ram_we), 0);
    chk("reissue_addr", 103, ram_addr, 32'h500);
    chk("reissue_wdata", 103, ram_wdata, 32'h99);
    ram_ack   = 1'b1;
    ram_rdata = 32'h5A5A0000;
    @(posedge clk);
    #1;
    ram_ack = 1'b0;
    chk("reissue_done_cs", 104, 32'(ram_cs), 0);
    chk("reissue_din", 104, mem_din, 32'h5A5A0000);
    chk("reissue_stall", 104, 32'(mem_stall), 0);
    mem_ren  = 1'b0;
    core_adv = 1'b1;
    @(posedge clk);
    #1;
    core_adv = 1'b0;
    chk("final_err", 105, 32'(err_timeout), 0);
    chk("final_cs", 105, 32'(ram_cs), 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
